// File: rtl/uart_imem_loader.sv
// UART (8N1) instruction-memory loader: packs four received bytes MSB-first
// into one 32-bit word and writes it to consecutive addresses from 0.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        last_byte,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic          rx_m, rxs;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    sh, sh_n;
    logic          byte_good, byte_bad;
    logic [1:0]    bcnt;
    logic [23:0]   word;

    assign fsm_state = state;

    // Synchronizer resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_n     = bit_idx;
        sh_n      = sh;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    sh_n  = {rxs, sh[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    byte_good = rxs;
                    byte_bad  = !rxs;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Word assembler; clr restarts the word but still keeps a byte accepted in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            last_byte <= '0;
            bcnt      <= '0;
            word      <= '0;
        end else begin
            we <= 1'b0;
            if (byte_good) last_byte <= sh;
            if (clr) begin
                wa        <= '0;
                done      <= 1'b0;
                frame_err <= 1'b0;
                bcnt      <= '0;
                if (byte_good) begin
                    word <= {word[15:0], sh};
                    bcnt <= 2'd1;
                end
            end else begin
                if (we) begin
                    if (wa == LAST) done <= 1'b1;
                    else            wa   <= wa + ADDR_W'(1);
                end
                if (byte_bad) begin
                    frame_err <= 1'b1;
                    bcnt      <= '0;
                end
                if (byte_good && !done) begin
                    if (bcnt == 2'd3) begin
                        wd   <= {word, sh};
                        we   <= 1'b1;
                        bcnt <= '0;
                    end else begin
                        word <= {word[15:0], sh};
                        bcnt <= bcnt + 2'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: expected {wa,wd} writes are queued as
// bytes are sent and checked on every we pulse; status outputs checked inline.
module tb_uart_imem_loader;
    localparam int CPB    = 8;
    localparam int ADDR_W = 2;
    localparam int W      = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              rst, clr, rx;
    logic              we, done, frame_err;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic [7:0]        last_byte;
    logic [1:0]        fsm_state;

    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .rx(rx),
        .we(we), .wa(wa), .wd(wd), .done(done), .frame_err(frame_err),
        .last_byte(last_byte), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest queued {wa,wd}.
    always @(negedge clk) begin
        if (rst && we === 1'b1) begin
            we_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                assert (1'b0) else begin
                    miscompares++;
                    $error("FAIL unexpected_we: observed wa=%h wd=%h expected no write", wa, wd);
                end
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                assert ({wa, wd} === e) else begin
                    miscompares++;
                    $error("FAIL write: observed wa=%h wd=%h expected wa=%h wd=%h",
                           wa, wd, e[W-1:32], e[31:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        if (!stop_bit) idle(2 * CPB);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_wa"}, 32'(wa), 32'd0);
        check({tag, "_wd"}, wd, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_last"}, 32'(last_byte), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        int we_before;
        rst = 1'b0;
        clr = 1'b0;
        rx  = 1'b1;
        idle(3);
        check_reset_vals("reset");
        rst = 1'b1;
        idle(4);

        // Single word
        send_word(2'd0, 32'h20080005);
        idle(4);
        check("t1_wa", 32'(wa), 32'd1);
        check("t1_last", 32'(last_byte), 32'h05);
        check("t1_we_cnt", 32'(we_cnt), 32'd1);
        check("t1_done", 32'(done), 32'd0);

        // Fill all four addresses, then extra bytes are ignored
        pulse_clr();
        check("t2_wa_clr", 32'(wa), 32'd0);
        for (int k = 1; k <= 4; k++) send_word(ADDR_W'(k - 1), 32'h11111111 * k);
        idle(4);
        check("t2_done", 32'(done), 32'd1);
        check("t2_wa", 32'(wa), 32'd3);
        we_before = we_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        idle(4);
        check("t2_no_we", 32'(we_cnt), 32'(we_before));
        check("t2_wa_hold", 32'(wa), 32'd3);
        check("t2_last", 32'(last_byte), 32'hBB);

        // Framing error resyncs the word
        pulse_clr();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        check("t3_ferr", 32'(frame_err), 32'd1);
        check("t3_last_kept", 32'(last_byte), 32'h34);
        send_word(2'd0, 32'hDEADBEEF);
        idle(4);
        check("t3_ferr_sticky", 32'(frame_err), 32'd1);
        check("t3_wa", 32'(wa), 32'd1);

        // Short glitch on rx is not a byte
        pulse_clr();
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2 * CPB);
        check("t4_state", 32'(fsm_state), 32'd0);
        check("t4_last", 32'(last_byte), 32'hEF);
        send_word(2'd0, 32'hCAFEBABE);
        idle(4);
        check("t4_wa", 32'(wa), 32'd1);

        // Reset in the middle of the second byte
        pulse_clr();
        send_byte(8'h11, 1'b1);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        rx = 1'b0;
        idle(CPB / 2);
        rst = 1'b0;
        idle(2);
        check_reset_vals("t5_rst");
        rx = 1'b1;
        idle(1);
        rst = 1'b1;
        idle(2 * CPB);
        send_word(2'd0, 32'h01020304);
        idle(4);
        check("t5_wa", 32'(wa), 32'd1);

        // clr after done and frame_err
        pulse_clr();
        send_byte(8'h99, 1'b0);
        for (int k = 0; k < 4; k++) send_word(ADDR_W'(k), 32'hA5000000 + 32'(k));
        idle(4);
        check("t6_done_set", 32'(done), 32'd1);
        check("t6_ferr_set", 32'(frame_err), 32'd1);
        pulse_clr();
        check("t6_done_clr", 32'(done), 32'd0);
        check("t6_ferr_clr", 32'(frame_err), 32'd0);
        check("t6_wa_clr", 32'(wa), 32'd0);
        send_word(2'd0, 32'h8C010007);
        idle(4);
        check("t6_wa", 32'(wa), 32'd1);
        check("t6_last", 32'(last_byte), 32'h07);

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
